// File: rtl/floppy_bank_if.sv
// Register bus between the AVR host and the floppy step generator.
// Ports:
//   reg_addr    - 6-bit register address
//   write       - 1 = write, 0 = read; only meaningful while new_req is high
//   new_req     - single-cycle request strobe
//   write_value - write data byte
//   read_value  - registered read data byte, driven by the slave
interface floppy_bank_if;
  logic [5:0] reg_addr;
  logic       write;
  logic       new_req;
  logic [7:0] write_value;
  logic [7:0] read_value;

  modport master (
    output reg_addr,
    output write,
    output new_req,
    output write_value,
    input  read_value
  );

  modport slave (
    input  reg_addr,
    input  write,
    input  new_req,
    input  write_value,
    output read_value
  );
endinterface

// File: rtl/floppy_bank.sv
// Multi-drive floppy step generator with an integrated register decoder.
// Each drive has an enable, a programmable half-period (shadowed, committed by
// the top byte write), head-track tracking and direction reversal at the limits.
// Ports:
//   clk   - system clock
//   rst   - asynchronous reset, active-high
//   bus   - register bus (slave side)
//   step  - per-drive step line
//   dir   - per-drive direction, 0 = toward higher track
//   sel_n - per-drive select, active-low (inverse of the enable bit)
module floppy_bank #(
  parameter int unsigned NUM_DRIVES = 4,
  parameter int unsigned PERIOD_W   = 23,
  parameter int unsigned MAX_TRACK  = 79
) (
  input  logic                  clk,
  input  logic                  rst,
  floppy_bank_if.slave          bus,
  output logic [NUM_DRIVES-1:0] step,
  output logic [NUM_DRIVES-1:0] dir,
  output logic [NUM_DRIVES-1:0] sel_n
);

  localparam int unsigned TRACK_W    = 7;
  localparam int unsigned ADDR_LIMIT = 8 * NUM_DRIVES;

  logic [PERIOD_W-1:0] period  [NUM_DRIVES];
  logic [PERIOD_W-1:0] counter [NUM_DRIVES];
  logic [7:0]          shadow1 [NUM_DRIVES];
  logic [7:0]          shadow2 [NUM_DRIVES];
  logic [TRACK_W-1:0]  track   [NUM_DRIVES];

  // Address decode: upper bits select the drive, lower bits the register.
  logic [2:0] drv_c;
  logic [2:0] off_c;
  logic       in_range_c;
  logic       wr_c;

  assign drv_c      = bus.reg_addr[5:3];
  assign off_c      = bus.reg_addr[2:0];
  assign in_range_c = {1'b0, bus.reg_addr} < 7'(ADDR_LIMIT);
  assign wr_c       = bus.new_req & bus.write & in_range_c;

  // Per-drive write strobes and stepping conditions.
  logic [NUM_DRIVES-1:0] hit_c;
  logic [NUM_DRIVES-1:0] commit_c;
  logic [NUM_DRIVES-1:0] active_c;
  logic [NUM_DRIVES-1:0] tc_c;

  always_comb begin
    hit_c    = '0;
    commit_c = '0;
    active_c = '0;
    tc_c     = '0;
    for (int unsigned d = 0; d < NUM_DRIVES; d++) begin
      hit_c[d]    = wr_c && (drv_c == 3'(d));
      commit_c[d] = hit_c[d] && (off_c == 3'd3);
      // A disable written this cycle already blocks a terminal-count toggle.
      active_c[d] = !sel_n[d] && (period[d] != '0) &&
                    !(hit_c[d] && (off_c == 3'd0) && !bus.write_value[0]);
      tc_c[d]     = counter[d] == (period[d] - PERIOD_W'(1));
    end
  end

  // Read mux: pick the addressed drive's state, then the register within it.
  logic [23:0]        psel_c;
  logic [TRACK_W-1:0] tsel_c;
  logic               esel_c;
  logic               ssel_c;
  logic               dsel_c;
  logic [7:0]         rdata_c;

  always_comb begin
    psel_c  = '0;
    tsel_c  = '0;
    esel_c  = 1'b0;
    ssel_c  = 1'b0;
    dsel_c  = 1'b0;
    rdata_c = '0;
    for (int unsigned d = 0; d < NUM_DRIVES; d++) begin
      if (drv_c == 3'(d)) begin
        psel_c = 24'(period[d]);
        tsel_c = track[d];
        esel_c = !sel_n[d];
        ssel_c = step[d];
        dsel_c = dir[d];
      end
    end
    if (in_range_c) begin
      case (off_c)
        3'd0:    rdata_c = {7'd0, esel_c};
        3'd1:    rdata_c = psel_c[7:0];
        3'd2:    rdata_c = psel_c[15:8];
        3'd3:    rdata_c = psel_c[23:16];
        3'd4:    rdata_c = 8'(tsel_c);
        3'd5:    rdata_c = {6'd0, ssel_c, dsel_c};
        default: rdata_c = '0;
      endcase
    end
  end

  // Read data register: only reads update it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.read_value <= '0;
    end else if (bus.new_req && !bus.write) begin
      bus.read_value <= rdata_c;
    end
  end

  // Register writes, step counters and head tracking for every drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step  <= '0;
      dir   <= '0;
      sel_n <= '1;
      for (int unsigned d = 0; d < NUM_DRIVES; d++) begin
        period[d]  <= '0;
        counter[d] <= '0;
        shadow1[d] <= '0;
        shadow2[d] <= '0;
        track[d]   <= '0;
      end
    end else begin
      for (int unsigned d = 0; d < NUM_DRIVES; d++) begin
        if (hit_c[d]) begin
          case (off_c)
            3'd0:    sel_n[d]   <= !bus.write_value[0];
            3'd1:    shadow1[d] <= bus.write_value;
            3'd2:    shadow2[d] <= bus.write_value;
            3'd3:    period[d]  <= PERIOD_W'({bus.write_value, shadow2[d], shadow1[d]});
            default: ;
          endcase
        end

        // Commit outranks a coincident terminal count: restart without toggling.
        if (commit_c[d]) begin
          counter[d] <= '0;
        end else if (!active_c[d]) begin
          counter[d] <= '0;
          step[d]    <= 1'b0;
        end else if (tc_c[d]) begin
          counter[d] <= '0;
          step[d]    <= !step[d];
          // Head moves on the rising edge of step; reverse at either limit.
          if (!step[d]) begin
            if (!dir[d]) begin
              if (track[d] < TRACK_W'(MAX_TRACK)) begin
                track[d] <= track[d] + TRACK_W'(1);
              end
              if (track[d] >= TRACK_W'(MAX_TRACK - 1)) begin
                dir[d] <= 1'b1;
              end
            end else begin
              if (track[d] != '0) begin
                track[d] <= track[d] - TRACK_W'(1);
              end
              if (track[d] <= TRACK_W'(1)) begin
                dir[d] <= 1'b0;
              end
            end
          end
        end else begin
          counter[d] <= counter[d] + PERIOD_W'(1);
        end
      end
    end
  end

endmodule
